// File: rtl/axi4_full_wr2umi_ost_if.sv
// AXI4 write channels (AW/W/B) plus UMI host request/response port for axi4_full_wr2umi_ost.
// slave: the bridge side; master: the AXI master / UMI device side (testbench).
interface axi4_full_wr2umi_ost_if #(
  parameter int CW  = 32,
  parameter int DW  = 128,
  parameter int AW  = 64,
  parameter int IDW = 8
);
  logic [IDW-1:0]  s_axi_awid;
  logic [AW-1:0]   s_axi_awaddr;
  logic [7:0]      s_axi_awlen;
  logic [2:0]      s_axi_awsize;
  logic [1:0]      s_axi_awburst;
  logic            s_axi_awlock;
  logic [3:0]      s_axi_awcache;
  logic [2:0]      s_axi_awprot;
  logic [3:0]      s_axi_awqos;
  logic            s_axi_awvalid;
  logic            s_axi_awready;
  logic [IDW-1:0]  s_axi_wid;
  logic [DW-1:0]   s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic            s_axi_wlast;
  logic            s_axi_wvalid;
  logic            s_axi_wready;
  logic [IDW-1:0]  s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready;
  logic            uhost_req_valid;
  logic [CW-1:0]   uhost_req_cmd;
  logic [AW-1:0]   uhost_req_dstaddr;
  logic [AW-1:0]   uhost_req_srcaddr;
  logic [DW-1:0]   uhost_req_data;
  logic            uhost_req_ready;
  logic            uhost_resp_valid;
  logic [CW-1:0]   uhost_resp_cmd;
  logic [AW-1:0]   uhost_resp_dstaddr;
  logic [AW-1:0]   uhost_resp_srcaddr;
  logic [DW-1:0]   uhost_resp_data;
  logic            uhost_resp_ready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
           s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
           uhost_req_ready, uhost_resp_valid, uhost_resp_cmd, uhost_resp_dstaddr,
           uhost_resp_srcaddr, uhost_resp_data,
    output s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
           uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr,
           uhost_req_data, uhost_resp_ready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
           s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
           uhost_req_ready, uhost_resp_valid, uhost_resp_cmd, uhost_resp_dstaddr,
           uhost_resp_srcaddr, uhost_resp_data,
    input  s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
           uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr,
           uhost_req_data, uhost_resp_ready
  );
endinterface

// File: rtl/axi4_full_wr2umi_ost.sv
// Pipelined AXI4 write -> UMI REQ_WRITE bridge keeping up to OSTD requests outstanding.
// Optional: define AXI4_WR2UMI_WRAP_EN to compute WRAP burst addresses (else WRAP acts as FIXED).
module axi4_full_wr2umi_ost #(
  parameter int            CW       = 32,
  parameter int            DW       = 128,
  parameter int            AW       = 64,
  parameter int            IDW      = 8,
  parameter int            OSTD     = 4,
  parameter logic [AW-1:0] HOSTADDR = '0
) (
  input logic                    clk,
  input logic                    nreset,
  axi4_full_wr2umi_ost_if.slave  axi_umi
);

  localparam int            SW         = DW / 8;
  localparam int            OW         = $clog2(OSTD + 1);
  localparam logic [OW-1:0] OSTD_W     = OW'(OSTD);
  localparam logic [OW-1:0] OST_ONE    = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [4:0]    REQ_WRITE  = 5'h03;
  localparam logic [4:0]    RESP_WRITE = 5'h04;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SEND_B} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     len_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic [1:0]     prot_q;
  logic [3:0]     qos_q;
  logic [1:0]     err_q, err_d;
  logic [OW-1:0]  ost_q, ost_d;

  logic strb_nz_s, room_s, req_valid_s, wready_s, awready_s, bvalid_s, resp_ready_s;
  logic aw_fire_s, w_fire_s, req_fire_s, resp_fire_s;

  function automatic logic [7:0] strb_len(input logic [SW-1:0] strb);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < SW; i++) begin
      cnt = cnt + {7'd0, strb[i]};
    end
    return cnt - 8'd1;
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [7:0] len);
    logic [AW-1:0] step;
    logic [AW-1:0] nxt;
`ifdef AXI4_WR2UMI_WRAP_EN
    logic [AW-1:0] wb;
    wb = ({{(AW-8){1'b0}}, len} + ADDR_ONE) << size;
`endif
    step = ADDR_ONE << size;
    case (burst)
      2'b01:   nxt = (addr & ~(step - ADDR_ONE)) + step;
`ifdef AXI4_WR2UMI_WRAP_EN
      2'b10:   nxt = (addr & ~(wb - ADDR_ONE)) | ((addr + step) & (wb - ADDR_ONE));
`endif
      default: nxt = addr;
    endcase
    return nxt;
  endfunction

  // A zero-strobe beat is consumed locally; only real beats need UMI credit and req_ready.
  assign strb_nz_s    = |axi_umi.s_axi_wstrb;
  assign room_s       = (ost_q < OSTD_W);
  assign req_valid_s  = (state_q == ISSUE) & axi_umi.s_axi_wvalid & strb_nz_s & room_s;
  assign wready_s     = (state_q == ISSUE) & (strb_nz_s ? (axi_umi.uhost_req_ready & room_s) : 1'b1);
  assign resp_ready_s = ((state_q == ISSUE) | (state_q == DRAIN)) & (ost_q != '0);

  assign aw_fire_s   = axi_umi.s_axi_awvalid & awready_s;
  assign w_fire_s    = axi_umi.s_axi_wvalid & wready_s;
  assign req_fire_s  = req_valid_s & axi_umi.uhost_req_ready;
  assign resp_fire_s = axi_umi.uhost_resp_valid & resp_ready_s;

  // FSM state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    awready_s = 1'b0;
    bvalid_s  = 1'b0;
    case (state_q)
      IDLE: begin
        awready_s = 1'b1;
        if (axi_umi.s_axi_awvalid) state_d = ISSUE;
        else                       state_d = IDLE;
      end
      ISSUE: begin
        if (w_fire_s && axi_umi.s_axi_wlast) state_d = DRAIN;
        else                                 state_d = ISSUE;
      end
      DRAIN: begin
        if (ost_q == '0) state_d = SEND_B;
        else             state_d = DRAIN;
      end
      SEND_B: begin
        bvalid_s = 1'b1;
        if (axi_umi.s_axi_bready) state_d = IDLE;
        else                      state_d = SEND_B;
      end
      default: state_d = IDLE;
    endcase
  end

  // Error latch: later errors overwrite, clean responses leave it alone
  always_comb begin
    err_d = err_q;
    if (aw_fire_s) begin
      err_d = 2'b00;
    end else if (resp_fire_s) begin
      if (axi_umi.uhost_resp_cmd[4:0] != RESP_WRITE)  err_d = 2'b10;
      else if (axi_umi.uhost_resp_cmd[26:25] != 2'b00) err_d = axi_umi.uhost_resp_cmd[26:25];
      else                                             err_d = err_q;
    end else begin
      err_d = err_q;
    end
  end

  // Outstanding request counter
  always_comb begin
    case ({req_fire_s, resp_fire_s})
      2'b10:   ost_d = ost_q + OST_ONE;
      2'b01:   ost_d = ost_q - OST_ONE;
      default: ost_d = ost_q;
    endcase
  end

  // Burst context capture and beat address advance
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'b00;
      prot_q  <= 2'b00;
      qos_q   <= 4'd0;
      err_q   <= 2'b00;
      ost_q   <= '0;
    end else begin
      err_q <= err_d;
      ost_q <= ost_d;
      if (aw_fire_s) begin
        addr_q  <= axi_umi.s_axi_awaddr;
        id_q    <= axi_umi.s_axi_awid;
        len_q   <= axi_umi.s_axi_awlen;
        size_q  <= axi_umi.s_axi_awsize;
        burst_q <= axi_umi.s_axi_awburst;
        prot_q  <= axi_umi.s_axi_awprot[1:0];
        qos_q   <= axi_umi.s_axi_awqos;
      end else if (w_fire_s) begin
        addr_q  <= next_addr(addr_q, size_q, burst_q, len_q);
      end
    end
  end

  // UMI request is a direct combinational view of the current W beat
  always_comb begin
    axi_umi.uhost_req_cmd        = '0;
    axi_umi.uhost_req_cmd[4:0]   = REQ_WRITE;
    axi_umi.uhost_req_cmd[15:8]  = strb_len(axi_umi.s_axi_wstrb);
    axi_umi.uhost_req_cmd[19:16] = qos_q;
    axi_umi.uhost_req_cmd[21:20] = prot_q;
    axi_umi.uhost_req_cmd[22]    = axi_umi.s_axi_wlast;
  end

  assign axi_umi.uhost_req_valid   = req_valid_s;
  assign axi_umi.uhost_req_dstaddr = addr_q;
  assign axi_umi.uhost_req_srcaddr = {HOSTADDR[AW-1:SW], axi_umi.s_axi_wstrb};
  assign axi_umi.uhost_req_data    = axi_umi.s_axi_wdata;
  assign axi_umi.uhost_resp_ready  = resp_ready_s;
  assign axi_umi.s_axi_awready     = awready_s;
  assign axi_umi.s_axi_wready      = wready_s;
  assign axi_umi.s_axi_bvalid      = bvalid_s;
  assign axi_umi.s_axi_bid         = id_q;
  assign axi_umi.s_axi_bresp       = err_q;

  logic unused_inputs;
  assign unused_inputs = ^{axi_umi.s_axi_awlock, axi_umi.s_axi_awcache, axi_umi.s_axi_awprot[2],
                           axi_umi.s_axi_wid, axi_umi.uhost_resp_cmd[CW-1:27],
                           axi_umi.uhost_resp_cmd[24:5], axi_umi.uhost_resp_dstaddr,
                           axi_umi.uhost_resp_srcaddr, axi_umi.uhost_resp_data, len_q};

endmodule

// File: tb/tb_axi4_full_wr2umi_ost.sv
// Scoreboard bench for axi4_full_wr2umi_ost: driver queues expected UMI requests and B ids,
// an independent negedge monitor compares them and models the outstanding count and bresp.
`timescale 1ns/1ps
module tb_axi4_full_wr2umi_ost;
  localparam int          CW = 32, DW = 128, AW = 64, IDW = 8, OSTD = 4;
  localparam logic [63:0] HOSTADDR      = 64'hABCD_0123_4567_0000;
  localparam int          TMO           = 2000;
  localparam logic [4:0]  OP_REQ_WRITE  = 5'h03;
  localparam logic [4:0]  OP_RESP_READ  = 5'h02;
  localparam logic [4:0]  OP_RESP_WRITE = 5'h04;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  axi4_full_wr2umi_ost_if #(.CW(CW), .DW(DW), .AW(AW), .IDW(IDW)) bus ();
  axi4_full_wr2umi_ost #(.CW(CW), .DW(DW), .AW(AW), .IDW(IDW), .OSTD(OSTD), .HOSTADDR(HOSTADDR))
    dut (.clk(clk), .nreset(nreset), .axi_umi(bus));

  typedef struct { logic [63:0] dst; logic [63:0] src; logic [31:0] cmd; logic [127:0] data; } req_t;
  typedef struct { logic [4:0] op; logic [1:0] err; } rsp_t;
  req_t       exp_q[$];
  logic [7:0] bid_q[$];
  rsp_t       script_q[$];

  int total = 0, bad = 0, cyc = 0, pend = 0, b_count = 0, last_w_cyc = 0, nb = 0;
  logic [1:0] cur_err = 2'b00, last_bresp = 2'b00;
  bit b_seen = 0, hold_resp = 0, resp_ok_only = 1, rr_rand = 0, w_gaps = 0, resp_fired = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected address of beat i from the AXI burst rules
  function automatic logic [63:0] beat_addr(input logic [63:0] a0, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [63:0] step, wb, base;
    step = 64'd1 << size;
    if (burst == 2'b01) begin
      if (i == 0) return a0;
      return (a0 & ~(step - 64'd1)) + step * 64'(i);
    end
`ifdef AXI4_WR2UMI_WRAP_EN
    if (burst == 2'b10) begin
      wb   = (64'(len) + 64'd1) * step;
      base = a0 & ~(wb - 64'd1);
      return base + ((a0 - base + step * 64'(i)) % wb);
    end
`endif
    wb = 64'd0; base = 64'd0;
    return a0;
  endfunction

  function automatic logic [31:0] exp_cmd(input logic [15:0] strb, input logic [3:0] qos,
                                          input logic [1:0] prot, input logic last);
    logic [31:0] c;
    c = 32'd0;
    c[4:0]   = OP_REQ_WRITE;
    c[15:8]  = 8'($countones(strb) - 1);
    c[19:16] = qos;
    c[21:20] = prot;
    c[22]    = last;
    return c;
  endfunction

  // Monitor / scoreboard
  initial forever begin
    bit rf, wf, sf, af, bf;
    req_t e;
    @(negedge clk);
    if (nreset) begin
      rf = bus.uhost_req_valid && bus.uhost_req_ready;
      wf = bus.s_axi_wvalid && bus.s_axi_wready;
      sf = bus.uhost_resp_valid && bus.uhost_resp_ready;
      af = bus.s_axi_awvalid && bus.s_axi_awready;
      bf = bus.s_axi_bvalid && bus.s_axi_bready;
      if (af) cur_err = 2'b00;
      if (wf) begin
        check("w_req_pair", 128'(rf), 128'(|bus.s_axi_wstrb));
        if (bus.s_axi_wlast) last_w_cyc = cyc;
      end
      if (rf) begin
        check("ost_limit", 128'(pend < OSTD), 128'd1);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL req_unexpected: dst %0h", bus.uhost_req_dstaddr);
        end else begin
          e = exp_q.pop_front();
          if (bus.uhost_req_dstaddr !== e.dst || bus.uhost_req_srcaddr !== e.src ||
              bus.uhost_req_cmd !== e.cmd || bus.uhost_req_data !== e.data) begin
            bad++;
            $display("FAIL req: dst %0h want %0h src %0h want %0h cmd %0h want %0h data_ok %0d",
                     bus.uhost_req_dstaddr, e.dst, bus.uhost_req_srcaddr, e.src,
                     bus.uhost_req_cmd, e.cmd, bus.uhost_req_data === e.data);
          end
        end
      end
      if (sf) begin
        if (bus.uhost_resp_cmd[4:0] != OP_RESP_WRITE)   cur_err = 2'b10;
        else if (bus.uhost_resp_cmd[26:25] != 2'b00)    cur_err = bus.uhost_resp_cmd[26:25];
        resp_fired = 1;
      end
      pend = pend + int'(rf) - int'(sf);
      if (bus.s_axi_bvalid && !b_seen) begin
        b_seen = 1;
        if (bid_q.size() == 0) check("b_unexpected", 128'd1, 128'd0);
        else                   check("bid", 128'(bus.s_axi_bid), 128'(bid_q[0]));
        check("bresp", 128'(bus.s_axi_bresp), 128'(cur_err));
        check("b_latency_ok", 128'((cyc - last_w_cyc) >= 2), 128'd1);
        check("b_ost_zero", 128'(pend), 128'd0);
        last_bresp = bus.s_axi_bresp;
      end
      if (bf) begin
        b_seen = 0;
        if (bid_q.size() != 0) void'(bid_q.pop_front());
        b_count++;
      end
    end
  end

  // UMI device and B-channel responder
  initial forever begin
    rsp_t r;
    logic [31:0] c;
    @(posedge clk); #1;
    bus.uhost_req_ready = rr_rand ? ($urandom_range(3) != 0) : 1'b1;
    bus.s_axi_bready    = ($urandom_range(1) == 1);
    if (!bus.uhost_resp_valid || resp_fired) begin
      resp_fired = 0;
      if (nreset && pend > 0 && !hold_resp && (script_q.size() > 0 || $urandom_range(2) != 0)) begin
        if (script_q.size() > 0) r = script_q.pop_front();
        else if (resp_ok_only) begin r.op = OP_RESP_WRITE; r.err = 2'b00; end
        else begin
          r.op  = ($urandom_range(9) == 0) ? OP_RESP_READ : OP_RESP_WRITE;
          r.err = ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : 2'b00;
        end
        c = $urandom;
        c[4:0] = r.op;
        c[26:25] = r.err;
        bus.uhost_resp_cmd     = c;
        bus.uhost_resp_dstaddr = {$urandom, $urandom};
        bus.uhost_resp_data    = {$urandom, $urandom, $urandom, $urandom};
        bus.uhost_resp_valid   = 1'b1;
      end else begin
        bus.uhost_resp_valid = 1'b0;
      end
    end
  end

  task automatic wait_hs(input bit is_w, input string nm);
    int t = 0;
    @(negedge clk);
    while (!(is_w ? bus.s_axi_wready : bus.s_axi_awready) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) check({nm, "_timeout"}, 128'd1, 128'd0);
  endtask

  task automatic wait_b(input int n);
    int t = 0;
    while (b_count < n && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (b_count < n) check("b_timeout", 128'(b_count), 128'(n));
  endtask

  // mode 0: random strobes, 1: full strobes from the address lane, 2: full with zero middle beat
  task automatic run_burst(input logic [7:0] id, input logic [63:0] a0, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    logic [2:0] prot;
    logic [3:0] qos;
    logic [63:0] ba;
    logic [31:0] s32;
    logic [15:0] strb;
    logic [127:0] d;
    req_t e;
    int lane, n;
    prot = 3'($urandom);
    qos  = 4'($urandom);
    bid_q.push_back(id);
    @(posedge clk); #1;
    bus.s_axi_awid = id; bus.s_axi_awaddr = a0; bus.s_axi_awlen = len; bus.s_axi_awsize = size;
    bus.s_axi_awburst = burst; bus.s_axi_awprot = prot; bus.s_axi_awqos = qos;
    bus.s_axi_awlock = 1'($urandom); bus.s_axi_awcache = 4'($urandom); bus.s_axi_awvalid = 1'b1;
    wait_hs(1'b0, "aw");
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (w_gaps && $urandom_range(3) == 0) begin
        bus.s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
      end
      ba   = beat_addr(a0, len, size, burst, i);
      lane = int'(ba[3:0]);
      s32  = 32'hFFFF << lane;
      if (mode == 0) begin
        n   = $urandom_range(16 - lane, 1);
        s32 = ($urandom_range(5) == 0) ? 32'd0 : (((32'd1 << n) - 32'd1) << lane);
      end else if (mode == 2 && i == 1) begin
        s32 = 32'd0;
      end
      strb = s32[15:0];
      d    = {$urandom, $urandom, $urandom, $urandom};
      bus.s_axi_wid = 8'($urandom); bus.s_axi_wdata = d; bus.s_axi_wstrb = strb;
      bus.s_axi_wlast = (i == int'(len)); bus.s_axi_wvalid = 1'b1;
      if (strb != 16'd0) begin
        e.dst = ba; e.src = {HOSTADDR[63:16], strb}; e.data = d;
        e.cmd = exp_cmd(strb, qos, prot[1:0], i == int'(len));
        exp_q.push_back(e);
      end
      wait_hs(1'b1, "w");
      @(posedge clk); #1;
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t e;
    int wl[4];
    logic [2:0] sz;
    logic [1:0] bt;
    logic [7:0] ln;
    logic [63:0] ad;
    wl = '{1, 3, 7, 15};
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
    bus.s_axi_awburst = '0; bus.s_axi_awlock = '0; bus.s_axi_awcache = '0; bus.s_axi_awprot = '0;
    bus.s_axi_awqos = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wid = '0; bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
    bus.uhost_req_ready = 1'b0; bus.uhost_resp_valid = 1'b0; bus.uhost_resp_cmd = '0;
    bus.uhost_resp_dstaddr = '0; bus.uhost_resp_srcaddr = '0; bus.uhost_resp_data = '0;
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 128'(bus.s_axi_awready), 128'd1);
    check("rst_wready", 128'(bus.s_axi_wready), 128'd0);
    check("rst_bvalid", 128'(bus.s_axi_bvalid), 128'd0);
    check("rst_bresp", 128'(bus.s_axi_bresp), 128'd0);
    check("rst_bid", 128'(bus.s_axi_bid), 128'd0);
    check("rst_req_valid", 128'(bus.uhost_req_valid), 128'd0);
    check("rst_resp_ready", 128'(bus.uhost_resp_ready), 128'd0);
    @(posedge clk); #1;
    nreset = 1'b1;

    // Single beat, AW and W presented together: W must wait one cycle
    bid_q.push_back(8'h5A);
    e.dst = 64'h1000; e.src = {HOSTADDR[63:16], 16'hFFFF}; e.data = {4{32'hC0DE_1234}};
    e.cmd = exp_cmd(16'hFFFF, 4'h9, 2'b11, 1'b1);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.s_axi_awid = 8'h5A; bus.s_axi_awaddr = 64'h1000; bus.s_axi_awlen = 8'd0; bus.s_axi_awsize = 3'd4;
    bus.s_axi_awburst = 2'b01; bus.s_axi_awprot = 3'b011; bus.s_axi_awqos = 4'h9; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata = {4{32'hC0DE_1234}}; bus.s_axi_wstrb = 16'hFFFF; bus.s_axi_wlast = 1'b1;
    bus.s_axi_wvalid = 1'b1;
    @(negedge clk);
    check("aw_cycle_awready", 128'(bus.s_axi_awready), 128'd1);
    check("aw_cycle_wready", 128'(bus.s_axi_wready), 128'd0);
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0;
    @(negedge clk);
    check("next_cycle_wready", 128'(bus.s_axi_wready), 128'd1);
    @(posedge clk); #1;
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
    nb++; wait_b(nb);
    check("single_bresp", 128'(last_bresp), 128'd0);

    // Responses held off: four requests in flight, fifth beat blocked
    hold_resp = 1;
    fork
      run_burst(8'h21, 64'h1000, 8'd4, 3'd4, 2'b01, 1);
      begin
        repeat (12) @(negedge clk);
        check("hold_pend", 128'(pend), 128'(OSTD));
        check("hold_wready", 128'(bus.s_axi_wready), 128'd0);
        check("hold_req_valid", 128'(bus.uhost_req_valid), 128'd0);
        check("hold_bvalid", 128'(bus.s_axi_bvalid), 128'd0);
        hold_resp = 0;
      end
    join
    nb++; wait_b(nb);

    // Error latching
    script_q.push_back('{OP_RESP_WRITE, 2'b00});
    script_q.push_back('{OP_RESP_WRITE, 2'b11});
    script_q.push_back('{OP_RESP_WRITE, 2'b00});
    run_burst(8'h33, 64'h2000, 8'd2, 3'd4, 2'b01, 1);
    nb++; wait_b(nb);
    check("err_overwrite_bresp", 128'(last_bresp), 128'd3);
    script_q.push_back('{OP_RESP_READ, 2'b00});
    run_burst(8'h34, 64'h2100, 8'd0, 3'd4, 2'b01, 1);
    nb++; wait_b(nb);
    check("bad_opcode_bresp", 128'(last_bresp), 128'd2);

    // WRAP burst and zero-strobe middle beat
    run_burst(8'h45, 64'h1030, 8'd3, 3'd4, 2'b10, 1);
    nb++; wait_b(nb);
    run_burst(8'h46, 64'h0, 8'd2, 3'd4, 2'b01, 2);
    nb++; wait_b(nb);
    check("zero_strobe_bresp", 128'(last_bresp), 128'd0);

    // Randomized bursts with back-pressure, gaps and error responses
    resp_ok_only = 0; rr_rand = 1; w_gaps = 1;
    repeat (40) begin
      sz = 3'($urandom_range(4));
      bt = 2'($urandom_range(2));
      ad = {$urandom, $urandom};
      if (bt == 2'b10) begin
        ln = 8'(wl[$urandom_range(3)]);
        ad = ad & ~((64'd1 << sz) - 64'd1);
      end else begin
        ln = 8'($urandom_range(7));
      end
      run_burst(8'($urandom), ad, ln, sz, bt, 0);
      nb++;
    end
    wait_b(nb);
    repeat (5) @(negedge clk);
    check("exp_req_drained", 128'(exp_q.size()), 128'd0);
    check("exp_b_drained", 128'(bid_q.size()), 128'd0);
    check("final_pend", 128'(pend), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
